// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_e;

  // Only the low two address bits decide alignment.
  function automatic logic misaligned(input logic [1:0] addr_lo, input size_e size);
    return ((size == SZ_HALF) && addr_lo[0]) ||
           ((size == SZ_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment: load extraction with sign/zero extension, and the
// merge of sub-word store data into the word read back from memory.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] read_data,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  size_e       size,
  input  logic        is_unsigned,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        sign_bit;

  always_comb begin
    byte_lane = read_data[7:0];
    case (offset)
      2'd0: byte_lane = read_data[7:0];
      2'd1: byte_lane = read_data[15:8];
      2'd2: byte_lane = read_data[23:16];
      2'd3: byte_lane = read_data[31:24];
      default: byte_lane = read_data[7:0];
    endcase
  end

  // Halfwords use offset[1] only; offset[0] is ignored when not trapping.
  assign half_lane = offset[1] ? read_data[31:16] : read_data[15:0];

  always_comb begin
    rdata    = '0;
    merged   = read_data;
    sign_bit = 1'b0;
    case (size)
      SZ_BYTE: begin
        sign_bit = ~is_unsigned & byte_lane[7];
        rdata    = {{24{sign_bit}}, byte_lane};
        case (offset)
          2'd0: merged[7:0]   = wdata[7:0];
          2'd1: merged[15:8]  = wdata[7:0];
          2'd2: merged[23:16] = wdata[7:0];
          2'd3: merged[31:24] = wdata[7:0];
          default: merged = read_data;
        endcase
      end
      SZ_HALF: begin
        sign_bit = ~is_unsigned & half_lane[15];
        rdata    = {{16{sign_bit}}, half_lane};
        if (offset[1]) merged[31:16] = wdata[15:0];
        else           merged[15:0]  = wdata[15:0];
      end
      SZ_WORD: begin
        rdata  = read_data;
        merged = wdata;
      end
      default: begin
        rdata  = '0;
        merged = read_data;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: load alignment/extension and read-modify-write
// for sub-word stores. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
//
// state | meaning
// IDLE  | ready for a request
// READ  | memory word sampled (load result or RMW base)
// WRITE | single-cycle full-word write strobe
// RESP  | response held until resp_ready
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic              memory_we,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data
);

  state_e            state_q;
  logic              we_q;
  size_e             size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              error_q;

  size_e             req_size_e;
  logic              req_err;
  logic [DATA_W-1:0] lane_rdata;
  logic [DATA_W-1:0] lane_merged;

  assign req_size_e = size_e'(req_size);

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_err = (req_size_e == SZ_ILL) || misaligned(req_addr[1:0], req_size_e);
`else
  assign req_err = (req_size_e == SZ_ILL);
`endif

  lsu_lane_align u_align (
    .read_data   (read_data),
    .wdata       (wdata_q),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .rdata       (lane_rdata),
    .merged      (lane_merged)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size_e;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            error_q <= req_err;
            if (req_err)                                state_q <= RESP;
            else if (!req_we || req_size_e != SZ_WORD)  state_q <= READ;
            else                                        state_q <= WRITE;
          end
        end
        READ: begin
          if (we_q) begin
            wdata_q <= lane_merged;
            state_q <= WRITE;
          end else begin
            rdata_q <= lane_rdata;
            state_q <= RESP;
          end
        end
        WRITE: state_q <= RESP;
        RESP: if (resp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Gated by reset so no request is taken while reset is held.
  assign req_ready  = (state_q == IDLE) && !reset;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_error = error_q;

  assign memory_we  = (state_q == WRITE);
  assign address    = (state_q == READ || state_q == WRITE) ?
                      {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign write_data = (state_q == WRITE) ? wdata_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a small word memory model.
module tb_load_store_unit;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          we;
    logic [31:0] wdata;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        memory_we;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  logic [31:0] mem [16];
  exp_t        sb [$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          we_cnt = 0;
  int          resp_lat = 0;
  logic [31:0] last_wdata = '0;
  logic        rv_prev = 1'b0;

  load_store_unit dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error),
    .memory_we    (memory_we),
    .address      (address),
    .write_data   (write_data),
    .read_data    (read_data)
  );

  always #5 clock = ~clock;

  assign read_data = mem[address[5:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] rdata, input logic err, input int lat,
                              input int we, input logic [31:0] wdata);
    exp_t e;
    e.rdata = rdata; e.err = err; e.lat = lat; e.we = we; e.wdata = wdata;
    return e;
  endfunction

  // Memory write port, accept tracking and write-strobe counting.
  always @(posedge clock) begin
    cyc = cyc + 1;
    if (req_valid && req_ready) begin
      acc_cyc = cyc;
      we_cnt  = 0;
    end
    if (memory_we) begin
      we_cnt++;
      last_wdata = write_data;
      check("addr_align", {30'd0, address[1:0]}, 32'd0);
      if (address[31:6] == '0) mem[address[5:2]] = write_data;
    end
  end

  always @(negedge clock) begin
    if (resp_valid && !rv_prev) resp_lat = cyc - acc_cyc + 1;
    rv_prev = resp_valid;
    if (resp_valid && resp_ready && !reset) begin
      if (sb.size() == 0) begin
        check("sb_underflow", sb.size(), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rdata", resp_rdata, e.rdata);
        check("error", {31'd0, resp_error}, {31'd0, e.err});
        check("latency", resp_lat, e.lat);
        check("we_count", we_cnt, e.we);
        if (e.we != 0) check("write_data", last_wdata, e.wdata);
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input exp_t e, input bit push, input bit drain);
    int n;
    @(negedge clock);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    if (push) sb.push_back(e);
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clock); n++; end
    if (!req_ready) check("accept_timeout", {31'd0, req_ready}, 32'd1);
    @(negedge clock);
    req_valid = 1'b0;
    if (drain) begin
      n = 0;
      while (sb.size() != 0 && n < 50) begin @(negedge clock); n++; end
      if (sb.size() != 0) check("resp_timeout", sb.size(), 0);
    end
  endtask

  initial begin
    logic [31:0] held_rdata;
    logic        held_err;
    int          n;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[2] = 32'h807060F0;
    mem[1] = 32'h11223344;

    repeat (2) @(negedge clock);
    check("rst_req_ready",  {31'd0, req_ready},  32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_memory_we",  {31'd0, memory_we},  32'd0);
    check("rst_address",    address,             32'd0);
    check("rst_write_data", write_data,          32'd0);
    check("rst_resp_rdata", resp_rdata,          32'd0);
    check("rst_resp_error", {31'd0, resp_error}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_req_ready", {31'd0, req_ready}, 32'd1);

    issue(0, 2'b00, 0, 32'h8, 0, mk(32'hFFFFFFF0, 0, 2, 0, 0), 1, 1);
    issue(0, 2'b00, 1, 32'hB, 0, mk(32'h00000080, 0, 2, 0, 0), 1, 1);
    issue(0, 2'b01, 0, 32'hA, 0, mk(32'hFFFF8070, 0, 2, 0, 0), 1, 1);
    issue(0, 2'b01, 1, 32'hA, 0, mk(32'h00008070, 0, 2, 0, 0), 1, 1);
    issue(0, 2'b10, 0, 32'h8, 0, mk(32'h807060F0, 0, 2, 0, 0), 1, 1);
    issue(1, 2'b00, 0, 32'h9, 32'hAB, mk(32'h0, 0, 3, 1, 32'h8070ABF0), 1, 1);
    issue(0, 2'b10, 0, 32'h8, 0, mk(32'h8070ABF0, 0, 2, 0, 0), 1, 1);
    issue(1, 2'b10, 0, 32'h8, 32'd999, mk(32'h0, 0, 2, 1, 32'd999), 1, 1);
    issue(0, 2'b10, 0, 32'h8, 0, mk(32'd999, 0, 2, 0, 0), 1, 1);
    issue(0, 2'b11, 0, 32'h8, 0, mk(32'h0, 1, 1, 0, 0), 1, 1);
`ifdef LSU_MISALIGN_TRAP_EN
    issue(0, 2'b10, 0, 32'h6, 0, mk(32'h0, 1, 1, 0, 0), 1, 1);
    issue(1, 2'b01, 0, 32'h7, 32'hBEEF, mk(32'h0, 1, 1, 0, 0), 1, 1);
    issue(0, 2'b10, 0, 32'h4, 0, mk(32'h11223344, 0, 2, 0, 0), 1, 1);
`else
    issue(0, 2'b10, 0, 32'h6, 0, mk(32'h11223344, 0, 2, 0, 0), 1, 1);
    issue(1, 2'b01, 0, 32'h7, 32'hBEEF, mk(32'h0, 0, 3, 1, 32'hBEEF3344), 1, 1);
    issue(0, 2'b10, 0, 32'h4, 0, mk(32'hBEEF3344, 0, 2, 0, 0), 1, 1);
`endif

    // Backpressure: response must hold while resp_ready is low.
    resp_ready = 1'b0;
    issue(0, 2'b00, 0, 32'h5, 0, mk(32'h00000033, 0, 2, 0, 0), 1, 0);
    n = 0;
    while (!resp_valid && n < 20) begin @(negedge clock); n++; end
    check("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
    held_rdata = resp_rdata;
    held_err   = resp_error;
    check("bp_rdata_value", held_rdata, 32'h00000033);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("bp_hold_valid", {31'd0, resp_valid}, 32'd1);
      check("bp_hold_rdata", resp_rdata, held_rdata);
      check("bp_hold_error", {31'd0, resp_error}, {31'd0, held_err});
      check("bp_req_ready",  {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 20) begin @(negedge clock); n++; end
    if (sb.size() != 0) check("bp_timeout", sb.size(), 0);

    // Reset during WRITE: strobe must drop at once and memory stay untouched.
    issue(1, 2'b10, 0, 32'h8, 32'h12345678, mk(0, 0, 0, 0, 0), 0, 0);
    check("pre_rst_we", {31'd0, memory_we}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_we_drop", {31'd0, memory_we}, 32'd0);
    check("rst_ready_low", {31'd0, req_ready}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    check("post_rst_valid", {31'd0, resp_valid}, 32'd0);
    check("post_rst_mem", mem[2], 32'd999);
    issue(0, 2'b10, 0, 32'h8, 0, mk(32'd999, 0, 2, 0, 0), 1, 1);

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Initiator side of the data-memory port. Accepts load/store requests from the CPU datapath over a valid/ready handshake and drives the single-word memory interface (memory_we, address, write_data, read_data). Performs byte-lane alignment for loads, with sign or zero extension. Implements byte and halfword stores as read-modify-write, because the memory only supports whole-word writes. Sits between the execute stage and data_memory.

Parameters:
- ADDR_W, 32, width of the request address and memory address.
- DATA_W, 32, word width; fixed at 32, with lane logic written for 4 bytes.

Ports:
- clock  in  1  system clock; all registers update on the rising edge.
- reset  in  1  asynchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- resp_error  out  1  request was illegal or misaligned.
- memory_we  out  1  word write strobe to memory.
- address  out  ADDR_W  word-aligned memory address; bits [1:0] are always 0.
- write_data  out  DATA_W  full word to write.
- read_data  in  DATA_W  combinational read of mem[address].

Behaviour:
- The memory model is a combinational read and a write on the rising edge when memory_we = 1.
- FSM states: IDLE, READ, WRITE, RESP.
- Reset, asynchronous: state = IDLE. All internal registers are cleared. memory_we = 0, resp_valid = 0, resp_rdata = 0, resp_error = 0, address = 0, write_data = 0. req_ready = 0 while reset is high.
- req_ready = (state == IDLE). A request is accepted on the edge where req_valid && req_ready; it is captured into registers.
- Transitions out of IDLE on accept:
  - error (size 11, or a misaligned access when trapping is enabled) -> RESP;
  - load -> READ;
  - word store -> WRITE;
  - byte or half store -> READ.
- READ:
  - Drives address = {addr_q[31:2], 2'b00} and samples read_data at the edge.
  - Load: next state RESP; rdata_q = extract(read_data, offset, size, unsigned).
  - Sub-word store: next state WRITE; wdata_q = merge(read_data, req_wdata_q, offset, size).
- WRITE: memory_we = 1 for exactly this one cycle; address = aligned address; write_data = wdata_q. Next state RESP.
- RESP: resp_valid = 1. Next state IDLE on resp_ready. Outputs are held stable while resp_ready = 0.
- memory_we = 0 in every state except WRITE. address = 0 and write_data = 0 in IDLE and RESP.
- Byte lanes are little-endian: offset k maps to bits [8k+7:8k].
- Half lanes: addr[1] selects [15:0] or [31:16].
- Sign extension uses the top bit of the selected lane.
- Latency, counted as cycles from the accept edge to the first cycle resp_valid is high: load 2, word store 2, sub-word store 3, error 1.
- Reset asserted mid-operation: memory_we drops immediately and no write occurs. Any pending response is discarded.
- resp_rdata is 0 for all stores.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: a halfword with addr[0] = 1, or a word with addr[1:0] != 0, goes IDLE -> RESP with resp_error = 1 and resp_rdata = 0. No memory access occurs.
- Undefined: the ignored low bits are treated as 0. A halfword uses addr[1] only; a word ignores addr[1:0]. resp_error = 1 only for size 11.

Decomposition:
- Package lsu_pkg holds:
  - size_e (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL);
  - state_e (IDLE, READ, WRITE, RESP);
  - a misaligned(addr, size) function.
- Sub-module lsu_lane_align (combinational):
  - extract path: read_data, offset, size, unsigned -> rdata;
  - merge path: read_data, wdata, offset, size -> merged word.
- The FSM and all registers live in load_store_unit.

Test Plan:
All scenarios preload mem[0x8] = 0x807060F0 and mem[0x4] = 0x11223344.
- Load byte signed at 0x8 -> resp_rdata = 0xFFFFFFF0, 2 cycles after accept. Load byte unsigned at 0xB -> 0x00000080.
- Load half signed at 0xA -> 0xFFFF8070. Load half unsigned at 0xA -> 0x00008070. Load word at 0x8 -> 0x807060F0.
- Store byte 0xAB at 0x9:
  - READ, then WRITE with memory_we high for exactly 1 cycle and write_data = 0x8070ABF0;
  - resp_valid 3 cycles after accept;
  - a following word load at 0x8 returns 0x8070ABF0.
- Store word 999 at 0x8, then load word at 0x8 -> 999. Illegal size 11 -> resp_error = 1, memory_we never asserted.
- Word load at 0x6:
  - with LSU_MISALIGN_TRAP_EN: resp_error = 1, no access, 1-cycle latency;
  - without it: resp_rdata = 0x11223344, resp_error = 0.
- Backpressure and reset:
  - Hold resp_ready = 0 for 3 cycles: resp_valid, resp_rdata and resp_error stay stable and req_ready = 0.
  - Assert reset during WRITE: memory_we falls immediately, memory is unchanged, and after release req_ready = 1 and resp_valid = 0.
